bydin_rs_arb: RTL and testbench

BYDIN_RS_ARB -- requirements
Module: bydin_rs_arb

---
 rtl/bydin_pkg.sv | 27 ++
 rtl/bydin_rs_arb_if.sv | 45 ++++
 rtl/bydin_rr_pick.sv | 38 +++
 rtl/bydin_rs_arb.sv | 199 +++++++++++++++++++
 tb/tb_bydin_rs_arb.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bydin_pkg.sv
// Shared types and constants for the RS decoder arbiter slice.
package bydin_pkg;

  // Width of one channel's RS mode field.
  localparam int RS_MODE_W  = 2;
  // Width of one channel's saturating failure counter.
  localparam int FAIL_CNT_W = 16;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Saturating increment for a failure counter: holds at all-ones.
  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] val);
    logic [FAIL_CNT_W-1:0] res;
    if (val == {FAIL_CNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(FAIL_CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/bydin_rs_arb_if.sv
// Channel-side and decoder-side bundle of the shared RS decoder arbiter.
interface bydin_rs_arb_if #(
  parameter int NCH = 2,
  parameter int DW  = 8
);
  import bydin_pkg::*;

  // Channel side
  logic [NCH-1:0]            ch_req;
  logic [RS_MODE_W*NCH-1:0]  ch_rs_mode;
  logic [NCH-1:0]            ch_en_in;
  logic [DW*NCH-1:0]         ch_din;
  logic [NCH-1:0]            ch_grant;
  logic [NCH-1:0]            ch_abort;
  logic [NCH-1:0]            ch_en_out;
  logic [DW-1:0]             ch_dout;
  logic [NCH-1:0]            fail_clr;
  logic [FAIL_CNT_W*NCH-1:0] fail_cnt;

  // Decoder side
  logic [RS_MODE_W-1:0]      rs_mode;
  logic                      rs_en_in;
  logic [DW-1:0]             rs_din;
  logic                      rs_row_finish;
  logic                      rs_cor_fail;
  logic                      rs_en_out;
  logic [DW-1:0]             rs_dout;

  // Environment view: drives channels and models the decoder.
  modport master (
    output ch_req, ch_rs_mode, ch_en_in, ch_din, fail_clr,
    output rs_row_finish, rs_cor_fail, rs_en_out, rs_dout,
    input  ch_grant, ch_abort, ch_en_out, ch_dout, fail_cnt,
    input  rs_mode, rs_en_in, rs_din
  );

  // Arbiter view.
  modport slave (
    input  ch_req, ch_rs_mode, ch_en_in, ch_din, fail_clr,
    input  rs_row_finish, rs_cor_fail, rs_en_out, rs_dout,
    output ch_grant, ch_abort, ch_en_out, ch_dout, fail_cnt,
    output rs_mode, rs_en_in, rs_din
  );

endinterface

// File: rtl/bydin_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first requester
// found at or after ptr, wrapping from NCH-1 back to 0.
module bydin_rr_pick #(
  parameter int NCH = 2,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] grant
);

  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;

  // Walk the channels in priority order starting at ptr; first hit wins.
  always_comb begin
    grant   = {NCH{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    sum_s   = {(PW+1){1'b0}};
    idx_s   = {PW{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      sum_s = {1'b0, ptr} + (PW+1)'(k);
      if (sum_s >= (PW+1)'(NCH)) begin
        sum_s = sum_s - (PW+1)'(NCH);
      end else begin
        sum_s = sum_s;
      end
      idx_s        = sum_s[PW-1:0];
      hit_s        = ~found_s & req[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/bydin_rs_arb.sv
// Shares one RS decoder among NCH TS channels: round-robin row grants,
// per-row timeout with abort pulse, and per-channel failure counters.
module bydin_rs_arb
  import bydin_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int TMO = 65535
) (
  input logic           clk,
  input logic           reset,
  bydin_rs_arb_if.slave bus
);

  localparam int          PW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [15:0] TMO_C  = 16'(TMO);
  localparam logic [15:0] TMO_M1 = 16'(TMO - 1);

  arb_state_e state_r, state_nx_s;

  logic [PW-1:0]        ptr_r, ptr_nx_s;
  logic [PW-1:0]        owner_r, owner_nx_s;
  logic [NCH-1:0]       grant_r, grant_nx_s;
  logic [NCH-1:0]       abort_r, abort_nx_s;
  logic [RS_MODE_W-1:0] rs_mode_r, rs_mode_nx_s;
  logic [15:0]          timer_r, timer_nx_s;
  logic                 inc_s;
  logic                 timeout_s;
  logic [PW-1:0]        ptr_adv_s;

  logic [NCH-1:0][FAIL_CNT_W-1:0] fail_cnt_r;
  logic [NCH-1:0]                 inc_vec_s;

  logic [NCH-1:0]       pick_gnt_s;
  logic [PW-1:0]        pick_idx_s;
  logic [RS_MODE_W-1:0] pick_mode_s;
  logic [DW-1:0]        din_sel_s;
  logic                 en_sel_s;

  bydin_rr_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_pick (
    .req   (bus.ch_req),
    .ptr   (ptr_r),
    .grant (pick_gnt_s)
  );

  assign timeout_s = (timer_r == TMO_C);
  assign ptr_adv_s = (owner_r == PW'(NCH - 1)) ? {PW{1'b0}} : owner_r + PW'(1);
  assign inc_vec_s = {NCH{inc_s}} & grant_r;

  // Encode the picker's one-hot result and fetch that channel's RS mode.
  always_comb begin
    pick_idx_s  = {PW{1'b0}};
    pick_mode_s = {RS_MODE_W{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      pick_idx_s  = pick_idx_s | (pick_gnt_s[k] ? PW'(k) : {PW{1'b0}});
      pick_mode_s = pick_mode_s |
                    (pick_gnt_s[k] ? bus.ch_rs_mode[RS_MODE_W*k +: RS_MODE_W]
                                   : {RS_MODE_W{1'b0}});
    end
  end

  // FSM state register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: a timed-out row takes precedence over a late finish.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|bus.ch_req) begin
          state_nx_s = ST_BUSY;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (timeout_s || bus.rs_row_finish) begin
          state_nx_s = ST_RELEASE;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_RELEASE: state_nx_s = ST_IDLE;
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs: next grant/owner/pointer/timer/abort/mode and fail increment.
  always_comb begin
    grant_nx_s   = grant_r;
    owner_nx_s   = owner_r;
    ptr_nx_s     = ptr_r;
    timer_nx_s   = timer_r;
    abort_nx_s   = {NCH{1'b0}};
    rs_mode_nx_s = rs_mode_r;
    inc_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|bus.ch_req) begin
          grant_nx_s   = pick_gnt_s;
          owner_nx_s   = pick_idx_s;
          rs_mode_nx_s = pick_mode_s;
          timer_nx_s   = 16'd0;
        end else begin
          grant_nx_s = {NCH{1'b0}};
        end
      end
      ST_BUSY: begin
        if (timeout_s) begin
          grant_nx_s = {NCH{1'b0}};
          ptr_nx_s   = ptr_adv_s;
          timer_nx_s = 16'd0;
        end else if (bus.rs_row_finish) begin
          grant_nx_s = {NCH{1'b0}};
          ptr_nx_s   = ptr_adv_s;
          timer_nx_s = 16'd0;
          inc_s      = bus.rs_cor_fail;
        end else if (timer_r == TMO_M1) begin
          // Abort is raised while the grant is still held; grant drops next cycle.
          abort_nx_s = grant_r;
          timer_nx_s = timer_r + 16'd1;
        end else begin
          timer_nx_s = timer_r + 16'd1;
        end
      end
      ST_RELEASE: grant_nx_s = {NCH{1'b0}};
      default:    grant_nx_s = {NCH{1'b0}};
    endcase
  end

  // Arbitration registers behind the FSM outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_r   <= {NCH{1'b0}};
      owner_r   <= {PW{1'b0}};
      ptr_r     <= {PW{1'b0}};
      timer_r   <= 16'd0;
      abort_r   <= {NCH{1'b0}};
      rs_mode_r <= {RS_MODE_W{1'b0}};
    end else begin
      grant_r   <= grant_nx_s;
      owner_r   <= owner_nx_s;
      ptr_r     <= ptr_nx_s;
      timer_r   <= timer_nx_s;
      abort_r   <= abort_nx_s;
      rs_mode_r <= rs_mode_nx_s;
    end
  end

  // Per-channel failure counters; a clear coinciding with a failure leaves 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_cnt_r <= {(NCH*FAIL_CNT_W){1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (bus.fail_clr[k]) begin
          fail_cnt_r[k] <= inc_vec_s[k] ? {{(FAIL_CNT_W-1){1'b0}}, 1'b1}
                                        : {FAIL_CNT_W{1'b0}};
        end else if (inc_vec_s[k]) begin
          fail_cnt_r[k] <= sat_inc(fail_cnt_r[k]);
        end
      end
    end
  end

  // Route the owner's symbol stream to the decoder; silence it outside BUSY.
  always_comb begin
    din_sel_s = {DW{1'b0}};
    en_sel_s  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      din_sel_s = din_sel_s | (grant_r[k] ? bus.ch_din[DW*k +: DW] : {DW{1'b0}});
      en_sel_s  = en_sel_s | (grant_r[k] & bus.ch_en_in[k]);
    end
    if (state_r == ST_BUSY) begin
      bus.rs_en_in = en_sel_s;
      bus.rs_din   = din_sel_s;
    end else begin
      bus.rs_en_in = 1'b0;
      bus.rs_din   = {DW{1'b0}};
    end
  end

  assign bus.ch_grant  = grant_r;
  assign bus.ch_abort  = abort_r;
  assign bus.rs_mode   = rs_mode_r;
  assign bus.ch_en_out = {NCH{bus.rs_en_out}} & grant_r;
  assign bus.ch_dout   = bus.rs_dout;
  assign bus.fail_cnt  = fail_cnt_r;

endmodule

// File: tb/tb_bydin_rs_arb.sv
// Self-checking bench for bydin_rs_arb: directed steps plus random rows
// checked against a row-level model of the arbitration rules.
module tb_bydin_rs_arb;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;

  int n_assert = 0;
  int n_fail   = 0;
  int m_ptr;
  int m_cnt [NCH];

  bydin_rs_arb_if #(.NCH(NCH), .DW(DW)) bus ();

  bydin_rs_arb #(.NCH(NCH), .DW(DW), .TMO(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_fail();
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < NCH; i++) v[16*i +: 16] = 16'(m_cnt[i]);
    return v;
  endfunction

  // First requester at or after the pointer, wrapping around.
  function automatic int pick(input logic [NCH-1:0] req, input int ptr);
    for (int k = 0; k < NCH; k++) begin
      if (req[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.ch_req        = 4'b0000;
    bus.ch_rs_mode    = 8'h00;
    bus.ch_en_in      = 4'b0000;
    bus.ch_din        = 32'h0;
    bus.fail_clr      = 4'b0000;
    bus.rs_row_finish = 1'b0;
    bus.rs_cor_fail   = 1'b0;
    bus.rs_en_out     = 1'b0;
    bus.rs_dout       = 8'h00;
  endtask

  // One complete row from IDLE back to IDLE. exp_own >= 0 pins the owner.
  task automatic do_row(input logic [3:0] req, input logic [7:0] modes, input int exp_own,
                        input int nbusy, input bit fin, input bit cf,
                        input logic [3:0] clr, input bit all_en);
    int own;
    logic [3:0]  own_oh;
    logic [3:0]  en;
    logic [31:0] din;
    logic        reo;
    logic [7:0]  rdo;
    logic [7:0]  exp_mode;
    own      = (exp_own >= 0) ? exp_own : pick(req, m_ptr);
    own_oh   = 4'b0001 << own;
    exp_mode = (modes >> (2*own)) & 8'h03;
    bus.ch_req     = req;
    bus.ch_rs_mode = modes;
    tick();
    chk("grant_on", bus.ch_grant, own_oh);
    chk("rs_mode_latch", bus.rs_mode, exp_mode);
    if ($urandom_range(0, 1) == 0) bus.ch_req = 4'b0000;
    else bus.ch_req = req;
    bus.ch_rs_mode = 8'($urandom);
    for (int c = 0; c < nbusy; c++) begin
      if (all_en) begin
        en = 4'hF; din = 32'h44332211; reo = 1'b1;
      end else begin
        en = 4'($urandom); din = $urandom; reo = 1'($urandom);
      end
      rdo = 8'($urandom);
      bus.ch_en_in = en; bus.ch_din = din; bus.rs_en_out = reo; bus.rs_dout = rdo;
      #1;
      chk("busy_grant", bus.ch_grant, own_oh);
      chk("rs_en_in", bus.rs_en_in, en[own]);
      chk("rs_din", bus.rs_din, din[8*own +: 8]);
      chk("ch_en_out", bus.ch_en_out, reo ? own_oh : 4'b0000);
      chk("ch_dout", bus.ch_dout, rdo);
      chk("rs_mode_hold", bus.rs_mode, exp_mode);
      tick();
    end
    bus.ch_en_in = 4'b0000; bus.rs_en_out = 1'b0;
    if (fin) begin
      bus.rs_row_finish = 1'b1; bus.rs_cor_fail = cf; bus.fail_clr = clr;
      tick();
      bus.rs_row_finish = 1'b0; bus.rs_cor_fail = 1'b0; bus.fail_clr = 4'b0000;
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) m_cnt[i] = (cf && i == own) ? 1 : 0;
        else if (cf && i == own && m_cnt[i] < 65535) m_cnt[i]++;
      end
      chk("release_grant", bus.ch_grant, 4'b0000);
      chk("finish_no_abort", bus.ch_abort, 4'b0000);
      chk("fail_cnt", bus.fail_cnt, exp_fail());
    end else begin
      for (int c = nbusy; c < TMO - 1; c++) tick();
      chk("pre_abort", bus.ch_abort, 4'b0000);
      tick();
      chk("abort_pulse", bus.ch_abort, own_oh);
      chk("abort_grant_held", bus.ch_grant, own_oh);
      tick();
      chk("abort_cleared", bus.ch_abort, 4'b0000);
      chk("abort_grant_drop", bus.ch_grant, 4'b0000);
      chk("abort_fail_cnt", bus.fail_cnt, exp_fail());
    end
    m_ptr = (own + 1) % NCH;
    bus.ch_req = 4'b0000;
    tick();
    chk("idle_grant", bus.ch_grant, 4'b0000);
  endtask

  initial begin
    logic [63:0] fv;
    idle_inputs();
    m_ptr = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;

    // Reset state, with noisy channel strobes that must not leak through
    reset = 1'b1;
    bus.ch_en_in = 4'hF; bus.ch_din = 32'hDEADBEEF; bus.rs_en_out = 1'b1;
    tick(); tick();
    chk("rst_grant", bus.ch_grant, 4'b0000);
    chk("rst_abort", bus.ch_abort, 4'b0000);
    chk("rst_rs_mode", bus.rs_mode, 2'b00);
    chk("rst_fail_cnt", bus.fail_cnt, 64'd0);
    chk("rst_rs_en_in", bus.rs_en_in, 1'b0);
    chk("rst_rs_din", bus.rs_din, 8'h00);
    chk("rst_ch_en_out", bus.ch_en_out, 4'b0000);
    reset = 1'b0;
    idle_inputs();
    tick();
    chk("idle_no_req", bus.ch_grant, 4'b0000);

    // Two persistent requesters alternate: 0, 1, then 0 again
    do_row(4'b0011, 8'b0000_0110, 0, 2, 1'b1, 1'b0, 4'b0000, 1'b0);
    do_row(4'b0011, 8'b0000_0110, 1, 2, 1'b1, 1'b0, 4'b0000, 1'b0);
    do_row(4'b0011, 8'b0000_0110, 0, 1, 1'b1, 1'b1, 4'b0000, 1'b0);

    // Owner 2 with every channel strobing distinct data
    do_row(4'b0100, 8'b0010_0000, 2, 3, 1'b1, 1'b0, 4'b0000, 1'b1);

    // Timeout: pointer at 3, requesters 1 and 3 -> owner 3 aborts
    do_row(4'b1010, 8'b1100_0000, 3, 2, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Finish strobe while idle must change nothing
    bus.rs_row_finish = 1'b1; bus.rs_cor_fail = 1'b1;
    tick();
    bus.rs_row_finish = 1'b0; bus.rs_cor_fail = 1'b0;
    chk("stray_finish_grant", bus.ch_grant, 4'b0000);
    chk("stray_finish_cnt", bus.fail_cnt, exp_fail());
    do_row(4'b1111, 8'hE4, 0, 1, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Saturation of channel 0 counter, then clear with simultaneous failure
    m_cnt[0] = 65535;
    fv = exp_fail();
    force dut.fail_cnt_r = fv;
    tick();
    release dut.fail_cnt_r;
    tick();
    chk("sat_preset", bus.fail_cnt, exp_fail());
    do_row(4'b0001, 8'h01, 0, 1, 1'b1, 1'b1, 4'b0000, 1'b0);
    chk("sat_hold", bus.fail_cnt[15:0], 16'hFFFF);
    do_row(4'b0001, 8'h01, 0, 1, 1'b1, 1'b1, 4'b0001, 1'b0);
    chk("clr_with_fail", bus.fail_cnt[15:0], 16'h0001);
    bus.fail_clr = 4'b0001;
    tick();
    bus.fail_clr = 4'b0000;
    m_cnt[0] = 0;
    chk("clr_alone", bus.fail_cnt, exp_fail());

    // Random rows against the model
    for (int r = 0; r < 40; r++) begin
      do_row(4'($urandom_range(1, 15)), 8'($urandom), -1, $urandom_range(0, 8),
             ($urandom_range(0, 9) != 0), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, 1'b0);
    end

    // Reset in the middle of a row: grant and strobe drop at once, no abort
    bus.ch_req = 4'b1000;
    tick();
    chk("pre_rst_grant", bus.ch_grant, 4'b1000);
    bus.ch_en_in = 4'hF; bus.ch_din = 32'hA5A5A5A5;
    #1;
    chk("pre_rst_en", bus.rs_en_in, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", bus.ch_grant, 4'b0000);
    chk("mid_rst_rs_en_in", bus.rs_en_in, 1'b0);
    chk("mid_rst_abort", bus.ch_abort, 4'b0000);
    chk("mid_rst_fail_cnt", bus.fail_cnt, 64'd0);
    #1;
    reset = 1'b0;
    idle_inputs();
    m_ptr = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    tick();
    chk("post_rst_abort", bus.ch_abort, 4'b0000);
    do_row(4'b1111, 8'h1B, 0, 1, 1'b1, 1'b0, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
